keccak_round_ctrl: RTL

//  Round sequencer for the Keccak-f[1600] permutation. Accepts a start request,

---
 rtl/keccak_pkg.sv | 14 +
 rtl/keccak_round_ctrl_if.sv | 22 ++
 rtl/keccak_round_constant_gen.sv | 13 +
 rtl/keccak_round_ctrl.sv | 57 +++++
 4 files changed

// File: rtl/keccak_pkg.sv
// keccak_pkg: shared parameters, FSM state type and iota constants for the Keccak-f[1600] round controller.
package keccak_pkg;
    localparam int NUM_ROUNDS_DEFAULT = 24;
    localparam int ROUND_W_DEFAULT = 5;
    typedef enum logic [1:0] {IDLE, ROUND, DONE} round_ctrl_state_t;
    localparam logic [63:0] ROUND_CONSTANTS [24] = '{
        64'h0000_0000_0000_0001, 64'h0000_0000_0000_8082, 64'h8000_0000_0000_808A, 64'h8000_0000_8000_8000,
        64'h0000_0000_0000_808B, 64'h0000_0000_8000_0001, 64'h8000_0000_8000_8081, 64'h8000_0000_0000_8009,
        64'h0000_0000_0000_008A, 64'h0000_0000_0000_0088, 64'h0000_0000_8000_8009, 64'h0000_0000_8000_000A,
        64'h0000_0000_8000_808B, 64'h8000_0000_0000_008B, 64'h8000_0000_0000_8089, 64'h8000_0000_0000_8003,
        64'h8000_0000_0000_8002, 64'h8000_0000_0000_0080, 64'h0000_0000_0000_800A, 64'h8000_0000_8000_000A,
        64'h8000_0000_8000_8081, 64'h8000_0000_0000_8080, 64'h0000_0000_8000_0001, 64'h8000_0000_8000_8008
    };
endpackage

// File: rtl/keccak_round_ctrl_if.sv
// keccak_round_ctrl_if: start/done handshakes and round-datapath controls between sponge control and round sequencer.
interface keccak_round_ctrl_if #(parameter int ROUND_W = keccak_pkg::ROUND_W_DEFAULT);
    logic start;
    logic in_ready;
    logic hold;
    logic abort;
    logic round_en;
    logic first_round;
    logic last_round;
    logic [ROUND_W-1:0] round_number;
    logic [63:0] round_constant;
    logic out_valid;
    logic out_ready;
    modport master (
        output start, hold, abort, out_ready,
        input in_ready, round_en, first_round, last_round, round_number, round_constant, out_valid
    );
    modport slave (
        input start, hold, abort, out_ready,
        output in_ready, round_en, first_round, last_round, round_number, round_constant, out_valid
    );
endinterface

// File: rtl/keccak_round_constant_gen.sv
// keccak_round_constant_gen: combinational iota constant lookup for a round index.
module keccak_round_constant_gen
    import keccak_pkg::*;
#(
    parameter int ROUND_W = ROUND_W_DEFAULT
) (
    input  logic [ROUND_W-1:0] round_number,
    output logic [63:0]        round_constant
);
    logic [4:0] idx;
    assign idx = 5'(round_number);
    assign round_constant = (idx < 5'd24) ? ROUND_CONSTANTS[idx] : '0;
endmodule

// File: rtl/keccak_round_ctrl.sv
// keccak_round_ctrl: sequences NUM_ROUNDS Keccak rounds per start request and hands the result off via valid/ready.
module keccak_round_ctrl
    import keccak_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT,
    parameter int ROUND_W = ROUND_W_DEFAULT
) (
    input logic clk,
    input logic rst_n,
    keccak_round_ctrl_if.slave bus
);
    localparam logic [ROUND_W-1:0] LAST = ROUND_W'(NUM_ROUNDS - 1);
    round_ctrl_state_t state_q, state_d;
    logic [ROUND_W-1:0] rn_q, rn_d;
    logic last;
    assign last = rn_q == LAST;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rn_q <= '0;
        end else begin
            state_q <= state_d;
            rn_q <= rn_d;
        end
    end
    always_comb begin
        state_d = state_q;
        rn_d = rn_q;
        if (bus.abort) begin
            state_d = IDLE;
            rn_d = '0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.start) begin
                    state_d = ROUND;
                    rn_d = '0;
                end
                ROUND: if (!bus.hold) begin
                    state_d = last ? DONE : ROUND;
                    rn_d = last ? '0 : rn_q + ROUND_W'(1);
                end
                DONE: state_d = bus.out_ready ? IDLE : DONE;
                default: state_d = IDLE;
            endcase
        end
    end
    assign bus.in_ready = state_q == IDLE;
    assign bus.round_en = (state_q == ROUND) && !bus.hold;
    assign bus.first_round = (state_q == ROUND) && (rn_q == '0);
    assign bus.last_round = (state_q == ROUND) && last;
    assign bus.out_valid = state_q == DONE;
    assign bus.round_number = rn_q;
    keccak_round_constant_gen #(.ROUND_W(ROUND_W)) u_rc (
        .round_number(rn_q),
        .round_constant(bus.round_constant)
    );
endmodule
